// File: rtl/screen_timing.sv
// Raster timing generator: free-running h/v counters, prefetch coordinate issue and
// display outputs aligned PF_LEAD+1 cycles later. Optional blink output: SCREEN_TIMING_BLINK_EN.
module screen_timing #(
  parameter int H_ACTIVE = 832,
  parameter int H_FP     = 32,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 96,
  parameter int V_ACTIVE = 448,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int PF_LEAD  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  output logic [9:0] pf_pix_row,
  output logic [9:0] pf_pix_col,
  output logic       pf_valid,
  input  logic [7:0] pix_val,
  output logic [7:0] pix_out,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
`ifdef SCREEN_TIMING_BLINK_EN
  output logic       blink,
`endif
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // 12-bit bounds so sync windows ending exactly at 2048 still compare correctly
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_bad_geom
    $error("screen_timing: raster geometry out of range");
  end
  if (PF_LEAD < 1 || PF_LEAD > 4) begin : g_bad_lead
    $error("screen_timing: PF_LEAD must be 1..4");
  end

  logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        running;
  logic        act_nxt, hs_nxt, vs_nxt, org_nxt;
  logic [PF_LEAD:0] vld_pipe, hs_pipe, vs_pipe, org_pipe;

  // First sampled run keeps the counters at 0,0 so pixel (0,0) is issued right away.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run && running) begin
      if (h_cnt != H_LAST) begin
        h_nxt = h_cnt + 11'd1;
        v_nxt = v_cnt;
      end else if (v_cnt != V_LAST) begin
        v_nxt = v_cnt + 11'd1;
      end
    end
  end

  assign act_nxt = run && ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
  assign hs_nxt  = !(run && ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
  assign vs_nxt  = !(run && ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
  assign org_nxt = act_nxt && (h_nxt == '0) && (v_nxt == '0);
  assign pf_valid = vld_pipe[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      running    <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pf_pix_row <= '0;
      pf_pix_col <= '0;
      vld_pipe   <= '0;
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      org_pipe   <= '0;
    end else begin
      running    <= run;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      pf_pix_col <= act_nxt ? h_nxt[9:0] : '0;
      pf_pix_row <= act_nxt ? v_nxt[9:0] : '0;
      vld_pipe   <= {vld_pipe[PF_LEAD-1:0], act_nxt};
      hs_pipe    <= {hs_pipe[PF_LEAD-1:0],  hs_nxt};
      vs_pipe    <= {vs_pipe[PF_LEAD-1:0],  vs_nxt};
      org_pipe   <= {org_pipe[PF_LEAD-1:0], org_nxt};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_out     <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_out     <= vld_pipe[PF_LEAD] ? pix_val : '0;
      de          <= vld_pipe[PF_LEAD];
      hsync       <= hs_pipe[PF_LEAD];
      vsync       <= vs_pipe[PF_LEAD];
      frame_start <= org_pipe[PF_LEAD];
    end
  end

`ifdef SCREEN_TIMING_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      frame_cnt <= '0;
    else if (!run)
      frame_cnt <= '0;
    else if (running && h_cnt == H_LAST && v_cnt == V_LAST)
      frame_cnt <= frame_cnt + 5'd1;
  end

  assign blink = frame_cnt[4];
`endif

endmodule

// File: tb/tb_screen_timing.sv
// Randomized run/reset stimulus with a position-based raster model; expectations are queued
// per cycle and a separate monitor compares the DUT outputs against them.
module tb_screen_timing;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int LEAD  = 2;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pix_val = 8'd0;
  logic [9:0] pf_pix_row, pf_pix_col;
  logic       pf_valid;
  logic [7:0] pix_out;
  logic       de, hsync, vsync, frame_start;
`ifdef SCREEN_TIMING_BLINK_EN
  logic       blink;
`endif

  screen_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PF_LEAD(LEAD)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .run(run),
    .pf_pix_row(pf_pix_row),
    .pf_pix_col(pf_pix_col),
    .pf_valid(pf_valid),
    .pix_val(pix_val),
    .pix_out(pix_out),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
`ifdef SCREEN_TIMING_BLINK_EN
    .blink(blink),
`endif
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit pfv;
    int row;
    int col;
    bit de;
    int pix;
    bit hs;
    bit vs;
    bit fs;
    bit bl;
  } exp_t;

  exp_t q[$];
  int   pos_h[int];      // raster position issued in each cycle, -1 when not running
  int   cyc = 0;
  int   k = 0;           // consecutive run cycles since the last stop/reset
  int   last_rst = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   seed = 0;
  logic [7:0] m1 = 8'd0, m2 = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pixf(input int row, input int col);
    return (row * 37 + col * 11 + seed) & 255;
  endfunction

  // Pixel memory with two cycles of latency, addressed by the DUT's prefetch coordinates.
  always @(negedge clk) begin
    pix_val = m2;
    m2 = m1;
    m1 = pf_valid ? 8'(pixf(int'(pf_pix_row), int'(pf_pix_col))) : 8'd0;
  end

  task automatic step(input bit rn, input bit r);
    exp_t e;
    int j, p, src, sp, sr, sc;
    @(negedge clk);
    #1;
    rstn = rn;
    run  = r;
    j = cyc + 1;
    if (!rn) begin
      k = 0;
      last_rst = j;
    end else if (r) k++;
    else k = 0;
    pos_h[j] = (k > 0) ? (k - 1) % FRAME : -1;

    e = '{default: 0};
    e.cyc = j;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    p = pos_h[j];
    if (p >= 0) begin
      e.row = p / HT;
      e.col = p % HT;
      e.pfv = (e.row < VA) && (e.col < HA);
      if (!e.pfv) begin
        e.row = 0;
        e.col = 0;
      end
      e.bl = (((k - 1) / FRAME) % 32) >= 16;
    end
    src = j - (LEAD + 1);
    if (rn && src > last_rst && pos_h.exists(src) && pos_h[src] >= 0) begin
      sp = pos_h[src];
      sr = sp / HT;
      sc = sp % HT;
      e.de  = (sr < VA) && (sc < HA);
      e.pix = e.de ? pixf(sr, sc) : 0;
      e.hs  = !((sc >= HA + HF) && (sc < HA + HF + HS));
      e.vs  = !((sr >= VA + VF) && (sr < VA + VF + VS));
      e.fs  = (sp == 0);
    end
    q.push_back(e);
  endtask

  task automatic run_for(input int n);
    repeat (n) step(1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("pf_valid",    int'(pf_valid),    int'(e.pfv));
      chk("pf_pix_row",  int'(pf_pix_row),  e.row);
      chk("pf_pix_col",  int'(pf_pix_col),  e.col);
      chk("de",          int'(de),          int'(e.de));
      chk("pix_out",     int'(pix_out),     e.pix);
      chk("hsync",       int'(hsync),       int'(e.hs));
      chk("vsync",       int'(vsync),       int'(e.vs));
      chk("frame_start", int'(frame_start), int'(e.fs));
`ifdef SCREEN_TIMING_BLINK_EN
      chk("blink",       int'(blink),       int'(e.bl));
`endif
    end
  end

  initial begin
    int n;
    seed = int'($urandom_range(0, 255));
    repeat (4) step(1'b0, 1'b0);
    idle(6);
    run_for(2 * FRAME + 40);          // crosses two frame wraps
    idle(5);
    run_for(13);                      // stop mid-line, then restart from 0,0
    idle(6);
    run_for(HT + 5);
    idle(3);
    for (int s = 0; s < 30; s++) begin
      idle(int'($urandom_range(0, 6)));
      n = int'($urandom_range(1, 3 * FRAME));
      if ($urandom_range(0, 5) == 0) begin
        run_for(n / 2);
        repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)));
        run_for(n / 2 + 1);
      end else begin
        run_for(n);
      end
    end
    idle(4);
    run_for(34 * FRAME + 20);         // blink rises after 16 frames, falls after 32
    idle(2);
    run_for(17 * FRAME + 50);         // reset while blink is high
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_for(30);
    idle(LEAD + 4);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
